dout_packer: RTL and testbench

DOUT_PACKER -- requirements
Module: dout_packer

---
 rtl/dout_packer.sv | 163 ++++++++++++++++
 tb/tb_dout_packer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dout_packer.sv
// dout_packer: gathers a length-delimited stream of bytes from an upstream
// byte source into 32-bit little-endian words with per-byte enables.
// Optional feature macro: DOUT_PACK_CSUM_EN appends one checksum word
// (8-bit modulo-256 sum of the frame bytes) after the final data word.
//
// Handshakes: every transfer happens on a rising CLK edge where the producer's
// "rdy" and the consumer's "en" are both 1. src_en is only asserted while
// collecting and then simply mirrors src_rdy. frm_len_en is ignored unless
// frm_len_rdy=1, and word_en is ignored unless word_rdy=1. Word outputs hold
// stable from word_rdy rising until the word_en edge that takes them.
module dout_packer (
  input  logic        CLK,
  input  logic        RST_N,          // active-high synchronous reset
  input  logic [7:0]  frm_len_value,
  input  logic        frm_len_en,
  output logic        frm_len_rdy,
  input  logic [7:0]  src_value,
  input  logic        src_rdy,
  output logic        src_en,
  output logic [31:0] word_value,
  output logic [3:0]  word_be,
  output logic        word_last,
  output logic        word_rdy,
  input  logic        word_en,
  output logic [1:0]  state_dbg
);

`ifdef DOUT_PACK_CSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_CSUM    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] lane_q;      // byte lanes of the word being assembled
  logic [3:0]  be_q;        // lanes filled so far
  logic [1:0]  idx_q;       // next lane to fill
  logic [8:0]  remain_q;    // bytes still to accept in this frame (1..256)
`ifdef DOUT_PACK_CSUM_EN
  logic [7:0]  sum_q;
`endif

  logic accept;
  logic word_done;
  logic take;

  assign accept    = (state_q == ST_COLLECT) && src_rdy;
  // The word closes on the 4th lane or on the frame's last byte.
  assign word_done = accept && ((idx_q == 2'd3) || (remain_q == 9'd1));
  assign take      = (state_q == ST_EMIT) && word_en;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST_N) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (frm_len_en) state_d = ST_COLLECT;
      ST_COLLECT: if (word_done)  state_d = ST_EMIT;
      ST_EMIT: begin
        if (word_en) begin
          if (remain_q != 9'd0) state_d = ST_COLLECT;
`ifdef DOUT_PACK_CSUM_EN
          else                  state_d = ST_CSUM;
`else
          else                  state_d = ST_IDLE;
`endif
        end
      end
`ifdef DOUT_PACK_CSUM_EN
      ST_CSUM:    if (word_en) state_d = ST_IDLE;
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  // Lane, byte-enable, count and checksum datapath.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      lane_q   <= 32'h0;
      be_q     <= 4'h0;
      idx_q    <= 2'd0;
      remain_q <= 9'd0;
`ifdef DOUT_PACK_CSUM_EN
      sum_q    <= 8'h0;
`endif
    end else begin
      if ((state_q == ST_IDLE) && frm_len_en) begin
        // A length of 0 stands for 256 bytes.
        remain_q <= {(frm_len_value == 8'd0), frm_len_value};
        lane_q   <= 32'h0;
        be_q     <= 4'h0;
        idx_q    <= 2'd0;
`ifdef DOUT_PACK_CSUM_EN
        sum_q    <= 8'h0;
`endif
      end
      if (accept) begin
        lane_q[{idx_q, 3'b000} +: 8] <= src_value;
        be_q[idx_q]                  <= 1'b1;
        idx_q                        <= idx_q + 2'd1;
        remain_q                     <= remain_q - 9'd1;
`ifdef DOUT_PACK_CSUM_EN
        sum_q                        <= sum_q + src_value;
`endif
      end
      if (take) begin
        lane_q <= 32'h0;
        be_q   <= 4'h0;
        idx_q  <= 2'd0;
      end
    end
  end

  // Outputs decoded from the state; word fields are zero unless presented.
  always_comb begin
    frm_len_rdy = 1'b0;
    src_en      = 1'b0;
    word_rdy    = 1'b0;
    word_value  = 32'h0;
    word_be     = 4'h0;
    word_last   = 1'b0;
    case (state_q)
      ST_IDLE:    frm_len_rdy = 1'b1;
      ST_COLLECT: src_en      = src_rdy;
      ST_EMIT: begin
        word_rdy   = 1'b1;
        word_value = lane_q;
        word_be    = be_q;
`ifdef DOUT_PACK_CSUM_EN
        word_last  = 1'b0;
`else
        word_last  = (remain_q == 9'd0);
`endif
      end
`ifdef DOUT_PACK_CSUM_EN
      ST_CSUM: begin
        word_rdy   = 1'b1;
        word_value = {24'h0, sum_q};
        word_be    = 4'b0001;
        word_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_dout_packer.sv
// tb_dout_packer: directed frames against a frame-level packing model, with
// literal expectations for the reference vectors.
module tb_dout_packer;

`ifdef DOUT_PACK_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  frm_len_value;
  logic        frm_len_en;
  logic        frm_len_rdy;
  logic [7:0]  src_value;
  logic        src_rdy;
  logic        src_en;
  logic [31:0] word_value;
  logic [3:0]  word_be;
  logic        word_last;
  logic        word_rdy;
  logic        word_en;
  logic [1:0]  state_dbg;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [36:0] exp_q[$];   // {last, be, value} words the DUT must present
  logic [36:0] got_q[$];   // words actually taken, for literal pins
  int          take_cyc[$];
  logic [7:0]  src_q[$];   // bytes the upstream source still holds
  logic [7:0]  fb[$];      // frame under construction
  bit          gap_mode = 1'b0;
  int          hold_left = 0;

  // clock / reset block
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got=timeout required=finish");
    $fatal(1);
  end

  dout_packer dut (
    .CLK(CLK), .RST_N(RST_N),
    .frm_len_value(frm_len_value), .frm_len_en(frm_len_en), .frm_len_rdy(frm_len_rdy),
    .src_value(src_value), .src_rdy(src_rdy), .src_en(src_en),
    .word_value(word_value), .word_be(word_be), .word_last(word_last),
    .word_rdy(word_rdy), .word_en(word_en), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h required=%h", name, got, exp);
  endtask

  // Frame model: chop the byte list into groups of four, little-endian,
  // then optionally append the checksum word.
  function automatic void model_frame(input logic [7:0] b[$]);
    int          n;
    logic [7:0]  sum;
    logic [31:0] w;
    logic [3:0]  be;
    logic        last;
    n   = b.size();
    sum = 8'h0;
    for (int i = 0; i < n; i += 4) begin
      w  = 32'h0;
      be = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (i + k < n) begin
          w[8*k +: 8] = b[i+k];
          be[k]       = 1'b1;
          sum         = sum + b[i+k];
        end
      end
      last = (i + 4 >= n) && !CSUM;
      exp_q.push_back({last, be, w});
    end
    if (CSUM) exp_q.push_back({1'b1, 4'b0001, 24'h0, sum});
  endfunction

  // driver: upstream byte source
  initial begin
    src_rdy   = 1'b0;
    src_value = 8'h00;
    forever begin
      @(negedge CLK);
      if (RST_N || src_q.size() == 0) begin
        src_rdy   = 1'b0;
        src_value = 8'h00;
      end else begin
        src_rdy   = gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        src_value = src_q[0];
      end
      @(posedge CLK);
      if (src_rdy && src_en && src_q.size() > 0) void'(src_q.pop_front());
    end
  end

  // scoreboard: compare every presented word with the model head, then sink it
  initial begin
    word_en = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N && word_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {63'h0, word_rdy}, 64'h0);
        end else begin
          check("word_value", {32'h0, word_value}, {32'h0, exp_q[0][31:0]});
          check("word_be", {60'h0, word_be}, {60'h0, exp_q[0][35:32]});
          check("word_last", {63'h0, word_last}, {63'h0, exp_q[0][36]});
          check("src_en_while_word", {63'h0, src_en}, 64'h0);
        end
      end
      if (word_rdy) begin
        if (hold_left > 0) begin
          word_en   = 1'b0;
          hold_left = hold_left - 1;
        end else begin
          word_en = 1'b1;
        end
      end else begin
        word_en = 1'($urandom_range(0, 1));
      end
      @(posedge CLK);
      if (!RST_N && word_rdy && word_en && exp_q.size() > 0) begin
        got_q.push_back({word_last, word_be, word_value});
        take_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic load_frame(input logic [7:0] len, input bit push_src);
    int t;
    t = 0;
    while (!frm_len_rdy && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    check("len_rdy_wait", {63'h0, frm_len_rdy}, 64'h1);
    frm_len_value = len;
    frm_len_en    = 1'b1;
    model_frame(fb);
    if (push_src) foreach (fb[i]) src_q.push_back(fb[i]);
    @(negedge CLK);
    frm_len_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    @(negedge CLK);
    while (!(exp_q.size() == 0 && frm_len_rdy) && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    check(name, {63'h0, (exp_q.size() == 0 && frm_len_rdy)}, 64'h1);
  endtask

  task automatic new_frame();
    got_q.delete();
    take_cyc.delete();
    fb.delete();
  endtask

  initial begin
    RST_N         = 1'b1;
    frm_len_en    = 1'b0;
    frm_len_value = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_frm_len_rdy", {63'h0, frm_len_rdy}, 64'h1);
    check("rst_src_en", {63'h0, src_en}, 64'h0);
    check("rst_word_rdy", {63'h0, word_rdy}, 64'h0);
    check("rst_word_value", {32'h0, word_value}, 64'h0);
    check("rst_word_be", {60'h0, word_be}, 64'h0);
    check("rst_word_last", {63'h0, word_last}, 64'h0);
    RST_N = 1'b0;
    @(negedge CLK);

    // len=4, 11 22 33 44
    new_frame();
    fb = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_frame(8'd4, 1'b1);
    wait_done("done_len4");
`ifdef DOUT_PACK_CSUM_EN
    check("pin_len4_w0", {27'h0, got_q[0]}, {27'h0, 1'b0, 4'hF, 32'h44332211});
    check("pin_len4_sum", {27'h0, got_q[1]}, {27'h0, 1'b1, 4'h1, 32'h000000AA});
`else
    check("pin_len4_w0", {27'h0, got_q[0]}, {27'h0, 1'b1, 4'hF, 32'h44332211});
`endif

    // len=6, 01..06
    new_frame();
    for (int i = 1; i <= 6; i++) fb.push_back(8'(i));
    load_frame(8'd6, 1'b1);
    wait_done("done_len6");
    check("pin_len6_w0", {27'h0, got_q[0]}, {27'h0, 1'b0, 4'hF, 32'h04030201});
`ifdef DOUT_PACK_CSUM_EN
    check("pin_len6_w1", {27'h0, got_q[1]}, {27'h0, 1'b0, 4'h3, 32'h00000605});
    check("pin_len6_sum", {27'h0, got_q[2]}, {27'h0, 1'b1, 4'h1, 32'h00000015});
`else
    check("pin_len6_w1", {27'h0, got_q[1]}, {27'h0, 1'b1, 4'h3, 32'h00000605});
`endif

    // len=0 means 256 bytes, 00..FF
    new_frame();
    for (int i = 0; i < 256; i++) fb.push_back(8'(i));
    load_frame(8'd0, 1'b1);
    wait_done("done_len256");
    check("len256_rdy_after", {63'h0, frm_len_rdy}, 64'h1);
`ifdef DOUT_PACK_CSUM_EN
    check("len256_words", 64'(got_q.size()), 64'd65);
    check("pin_len256_w63", {27'h0, got_q[63]}, {27'h0, 1'b0, 4'hF, 32'hFFFEFDFC});
    check("pin_len256_sum", {27'h0, got_q[64]}, {27'h0, 1'b1, 4'h1, 32'h00000080});
`else
    check("len256_words", 64'(got_q.size()), 64'd64);
    check("pin_len256_w63", {27'h0, got_q[63]}, {27'h0, 1'b1, 4'hF, 32'hFFFEFDFC});
`endif

    // downstream stall of 10 cycles with the next frame's bytes waiting
    new_frame();
    hold_left = 10;
    fb = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    load_frame(8'd4, 1'b1);
    foreach (fb[i]) src_q.push_back(8'(fb[i] + 8'h10));
    wait_done("done_stall_a");
    check("stall_bytes_intact", 64'(src_q.size()), 64'd4);
    check("pin_stall_a", {59'h0, got_q[0][35:32], 1'b0}, {59'h0, 4'hF, 1'b0});
    check("pin_stall_a_val", {32'h0, got_q[0][31:0]}, 64'hA4A3A2A1);
    new_frame();
    fb = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    load_frame(8'd4, 1'b0);
    wait_done("done_stall_b");
    check("pin_stall_b_val", {32'h0, got_q[0][31:0]}, 64'hB4B3B2B1);

    // unstalled throughput: consecutive full words no more than 5 cycles apart
    new_frame();
    for (int i = 0; i < 8; i++) fb.push_back(8'($urandom_range(0, 255)));
    load_frame(8'd8, 1'b1);
    wait_done("done_len8");
    check("throughput", {63'h0, (take_cyc.size() >= 2 && take_cyc[1] - take_cyc[0] <= 5)}, 64'h1);

    // upstream gaps plus a length write that must be ignored mid-frame
    new_frame();
    gap_mode = 1'b1;
    for (int i = 0; i < 13; i++) fb.push_back(8'($urandom_range(0, 255)));
    load_frame(8'd13, 1'b1);
    repeat (3) @(negedge CLK);
    frm_len_value = 8'd2;
    frm_len_en    = 1'b1;
    @(negedge CLK);
    frm_len_en = 1'b0;
    wait_done("done_gaps");
    gap_mode = 1'b0;
    check("gaps_words", 64'(got_q.size()), CSUM ? 64'd5 : 64'd4);

    // reset after two bytes of a len=8 frame
    begin
      int t;
      new_frame();
      for (int i = 0; i < 8; i++) fb.push_back(8'(8'hC0 + 8'(i)));
      load_frame(8'd8, 1'b1);
      t = 0;
      while (src_q.size() > 6 && t < 100) begin
        @(negedge CLK);
        t++;
      end
      check("two_bytes_taken", {63'h0, (src_q.size() <= 6)}, 64'h1);
      RST_N = 1'b1;
      exp_q.delete();
      src_q.delete();
      @(negedge CLK);
      RST_N = 1'b0;
      check("post_rst_frm_len_rdy", {63'h0, frm_len_rdy}, 64'h1);
      check("post_rst_word_rdy", {63'h0, word_rdy}, 64'h0);
      repeat (4) @(negedge CLK);
      check("post_rst_no_words", 64'(got_q.size()), 64'd0);
    end
    new_frame();
    fb = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    load_frame(8'd4, 1'b1);
    wait_done("done_after_rst");
    check("pin_after_rst", {32'h0, got_q[0][31:0]}, 64'h8D7C6B5A);

`ifdef DOUT_PACK_CSUM_EN
    // checksum vector: 80 80 01
    new_frame();
    fb = '{8'h80, 8'h80, 8'h01};
    load_frame(8'd3, 1'b1);
    wait_done("done_csum");
    check("pin_csum_w0", {27'h0, got_q[0]}, {27'h0, 1'b0, 4'h7, 32'h00018080});
    check("pin_csum_w1", {27'h0, got_q[1]}, {27'h0, 1'b1, 4'h1, 32'h00000001});
`endif

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
